kc_clk_reset_ctrl: RTL and testbench

Consumer end of the system PLL, which produces a 56.75 MHz clk_sys plus an asynchronous locked flag. The block synchronises locked, qualifies it for a stable period, and sequences the core reset. It also generates phase-aligned clock-enable pulses from clk_sys: CPU 1.7734 MHz (/32) and pixel 7.09375 MHz (/8). It sits between the PLL wrapper and the KC85/4 core top.

---
 rtl/kc_clk_pkg.sv | 23 ++
 rtl/kc_sync2.sv | 26 ++
 rtl/kc_clk_reset_ctrl.sv | 160 ++++++++++++++++
 tb/tb_kc_clk_reset_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/kc_clk_pkg.sv
// KC85/4 clock/reset controller shared types.
// FSM states, divider defaults and loss counter width.
package kc_clk_pkg;

  typedef enum logic [1:0] {
    S_WAIT,
    S_STAB,
    S_HOLD,
    S_RUN
  } kc_state_e;

  localparam int CPU_DIV_DEF = 32;
  localparam int PIX_DIV_DEF = 8;
  localparam int LOSS_CNT_W  = 8;

  // Increment that sticks at all-ones.
  function automatic logic [LOSS_CNT_W-1:0] sat_inc(
    input logic [LOSS_CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/kc_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
// Synchronous active-high reset clears both stages.
module kc_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // Shift the async level through two flops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/kc_clk_reset_ctrl.sv
// PLL lock qualification, core reset sequencing and
// phase-aligned CPU/pixel clock enables from clk_sys.
module kc_clk_reset_ctrl
  import kc_clk_pkg::*;
#(
  parameter int STABLE_CYCLES = 1024,
  parameter int RST_HOLD      = 16,
  parameter int CPU_DIV       = CPU_DIV_DEF,
  parameter int PIX_DIV       = PIX_DIV_DEF
) (
  input  logic                  clk_sys,
  input  logic                  rst,
  input  logic                  pll_locked,
  output logic                  rst_out,
  output logic                  cpu_cen,
  output logic                  pix_cen,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

  localparam int DIV_W  = $clog2(CPU_DIV);
  localparam int PIX_W  = $clog2(PIX_DIV);
  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam int HOLD_W = $clog2(RST_HOLD + 1);

  localparam logic [STAB_W-1:0] STAB_LAST =
    STAB_W'(STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'(RST_HOLD - 1);

  logic                  lock_s;
  kc_state_e             state_q, state_d;
  logic [STAB_W-1:0]     stab_cnt_q, stab_cnt_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;
  logic                  rst_out_q, rst_out_d;
  logic                  cpu_cen_q, cpu_cen_d;
  logic                  pix_cen_q, pix_cen_d;
  logic                  ready_q, ready_d;
  logic                  stab_done;
  logic                  hold_done;
  logic                  loss_evt;

  kc_sync2 u_lock_sync (
    .clk_i (clk_sys),
    .rst_i (rst),
    .d_i   (pll_locked),
    .q_o   (lock_s)
  );

  assign stab_done = lock_s && (stab_cnt_q == STAB_LAST);
  assign hold_done = cpu_cen_q && (hold_cnt_q == HOLD_LAST);
  assign loss_evt  = (state_q == S_RUN) && !lock_s;

  // State register.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= S_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a lock drop always wins over progress.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_WAIT: begin
        if (lock_s) state_d = S_STAB;
      end
      S_STAB: begin
        if (!lock_s)        state_d = S_WAIT;
        else if (stab_done) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!lock_s)        state_d = S_WAIT;
        else if (hold_done) state_d = S_RUN;
      end
      S_RUN: begin
        if (!lock_s) state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  // Counter next values: stability, hold pulses, divider, losses.
  always_comb begin
    stab_cnt_d = '0;
    if (state_q == S_STAB && lock_s && !stab_done) begin
      stab_cnt_d = stab_cnt_q + 1'b1;
    end

    hold_cnt_d = '0;
    if (state_q == S_HOLD && lock_s) begin
      hold_cnt_d = cpu_cen_q ? hold_cnt_q + 1'b1 : hold_cnt_q;
    end

    if (state_q == S_STAB && state_d == S_HOLD) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end

    loss_d = loss_evt ? sat_inc(loss_q) : loss_q;
  end

  // Output decode from the upcoming state so outputs are registered.
  always_comb begin
    rst_out_d = 1'b1;
    ready_d   = 1'b0;
    cpu_cen_d = 1'b0;
    pix_cen_d = 1'b0;
    unique case (state_d)
      S_HOLD: begin
        cpu_cen_d = &div_cnt_d;
        pix_cen_d = &div_cnt_d[PIX_W-1:0];
      end
      S_RUN: begin
        rst_out_d = 1'b0;
        ready_d   = 1'b1;
        cpu_cen_d = &div_cnt_d;
        pix_cen_d = &div_cnt_d[PIX_W-1:0];
      end
      default: begin
        rst_out_d = 1'b1;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      stab_cnt_q <= '0;
      hold_cnt_q <= '0;
      div_cnt_q  <= '0;
      loss_q     <= '0;
      rst_out_q  <= 1'b1;
      cpu_cen_q  <= 1'b0;
      pix_cen_q  <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      stab_cnt_q <= stab_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      div_cnt_q  <= div_cnt_d;
      loss_q     <= loss_d;
      rst_out_q  <= rst_out_d;
      cpu_cen_q  <= cpu_cen_d;
      pix_cen_q  <= pix_cen_d;
      ready_q    <= ready_d;
    end
  end

  assign rst_out       = rst_out_q;
  assign cpu_cen       = cpu_cen_q;
  assign pix_cen       = pix_cen_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_kc_clk_reset_ctrl.sv
// Directed bench for kc_clk_reset_ctrl with short
// stability/hold settings.
module tb_kc_clk_reset_ctrl;

  logic       clk_sys = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       rst_out;
  logic       cpu_cen;
  logic       pix_cen;
  logic       ready;
  logic [7:0] lock_loss_cnt;

  int checks = 0;
  int errors = 0;

  kc_clk_reset_ctrl #(
    .STABLE_CYCLES (8),
    .RST_HOLD      (2),
    .CPU_DIV       (32),
    .PIX_DIV       (8)
  ) dut (
    .clk_sys       (clk_sys),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .rst_out       (rst_out),
    .cpu_cen       (cpu_cen),
    .pix_cen       (pix_cen),
    .ready         (ready),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Run 80 cycles after lock is presented; record first events.
  task automatic bring_up(
    output int fp,
    output int fc,
    output int fall,
    output int bad
  );
    fp = -1;
    fc = -1;
    fall = -1;
    bad = 0;
    for (int n = 1; n <= 80; n++) begin
      tick();
      if (pix_cen && fp < 0) fp = n;
      if (cpu_cen && fc < 0) fc = n;
      if (!rst_out && fall < 0) fall = n;
      if (ready !== !rst_out) bad++;
      if (cpu_cen && !pix_cen) bad++;
    end
  endtask

  initial begin
    int fp, fc, fall, bad;
    int npix, ncpu, nlone, nlow;

    // Reset with PLL unlocked.
    repeat (3) tick();
    chk("rst_rst_out", rst_out, 1);
    chk("rst_cpu_cen", cpu_cen, 0);
    chk("rst_pix_cen", pix_cen, 0);
    chk("rst_ready", ready, 0);
    chk("rst_loss", lock_loss_cnt, 0);
    rst = 1'b0;
    nlow = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (!rst_out || cpu_cen || pix_cen || ready) nlow++;
    end
    chk("idle_hold", nlow, 0);

    // Short lock glitch during stabilisation.
    pll_locked = 1'b1;
    repeat (5) tick();
    pll_locked = 1'b0;
    nlow = 0;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (!rst_out || cpu_cen || pix_cen) nlow++;
    end
    chk("glitch_no_release", nlow, 0);
    chk("glitch_loss", lock_loss_cnt, 0);

    // Full bring-up from a clean wait state.
    pll_locked = 1'b1;
    bring_up(fp, fc, fall, bad);
    chk("first_pix_cen", fp, 18);
    chk("first_cpu_cen", fc, 42);
    chk("rst_out_fall", fall, 75);
    chk("bringup_consistency", bad, 0);
    chk("run_ready", ready, 1);

    // Enable cadence over 64 cycles in run.
    npix = 0;
    ncpu = 0;
    nlone = 0;
    for (int n = 0; n < 64; n++) begin
      tick();
      if (pix_cen) npix++;
      if (cpu_cen) ncpu++;
      if (cpu_cen && !pix_cen) nlone++;
    end
    chk("pix_count", npix, 8);
    chk("cpu_count", ncpu, 2);
    chk("cpu_without_pix", nlone, 0);
    chk("run_loss", lock_loss_cnt, 0);

    // First lock loss in run.
    pll_locked = 1'b0;
    tick();
    chk("drop_t1_rst_out", rst_out, 0);
    tick();
    chk("drop_t2_rst_out", rst_out, 0);
    tick();
    chk("drop_t3_rst_out", rst_out, 1);
    chk("drop_t3_ready", ready, 0);
    chk("drop_loss", lock_loss_cnt, 1);

    // Repeated losses saturate the counter.
    for (int i = 2; i <= 300; i++) begin
      pll_locked = 1'b1;
      bring_up(fp, fc, fall, bad);
      chk("relock_fall", fall, 75);
      pll_locked = 1'b0;
      repeat (3) tick();
      chk("loss_cnt", lock_loss_cnt, (i > 255) ? 255 : i);
    end
    chk("loss_saturated", lock_loss_cnt, 255);

    // Reset pulse in the middle of hold.
    pll_locked = 1'b1;
    repeat (30) tick();
    chk("hold_rst_out", rst_out, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_rst_out", rst_out, 1);
    chk("midrst_cpu_cen", cpu_cen, 0);
    chk("midrst_pix_cen", pix_cen, 0);
    chk("midrst_ready", ready, 0);
    chk("midrst_loss", lock_loss_cnt, 0);
    bring_up(fp, fc, fall, bad);
    chk("restart_first_pix", fp, 18);
    chk("restart_first_cpu", fc, 42);
    chk("restart_fall", fall, 75);
    chk("restart_consistency", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
